fifo_burst_reader: RTL and testbench



---
 rtl/fifo_burst_reader_pkg.sv | 9 +
 rtl/fifo_burst_reader.sv | 133 +++++++++++++
 tb/tb_fifo_burst_reader.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_burst_reader_pkg.sv
// Shared types for the FIFO burst reader: controller state encoding and FIFO read latency.
package fifo_burst_reader_pkg;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DONE} state_t;

  // Cycles from o_rd_en to i_rd_dv; WAIT is one cycle long because this is 1.
  localparam int RD_LATENCY = 1;

endpackage

// File: rtl/fifo_burst_reader.sv
// Read-side FIFO controller: drains bursts (or flushes to empty) onto a valid/ready stream.
// Optional macro FIFO_BURST_READER_STATS_EN adds the o_words_sent transfer counter.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 16,
  parameter int STATS_W   = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [$clog2(MAX_BURST+1)-1:0] i_burst_len,
  input  logic                           i_flush,
  output logic                           o_rd_en,
  input  logic                           i_rd_dv,
  input  logic [WIDTH-1:0]               i_rd_data,
  input  logic                           i_empty,
  input  logic                           i_ae_flag,
  output logic                           o_tx_dv,
  output logic [WIDTH-1:0]               o_tx_data,
  input  logic                           i_tx_ready,
  output logic                           o_busy,
  output logic                           o_burst_done,
`ifdef FIFO_BURST_READER_STATS_EN
  output logic [STATS_W-1:0]             o_words_sent,
`endif
  output logic                           o_err
);

  localparam int               LEN_W   = $clog2(MAX_BURST + 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic               flush_q, flush_d;
  logic               tx_dv_q, tx_dv_d;
  logic [WIDTH-1:0]   tx_data_q, tx_data_d;
  logic               err_q, err_d;
  logic               xfer;
  logic               flush_eff;

  assign xfer      = tx_dv_q && i_tx_ready;
  assign flush_eff = flush_q || i_flush;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    flush_d     = flush_q;
    tx_dv_d     = tx_dv_q;
    tx_data_d   = tx_data_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if ((!i_ae_flag && i_burst_len != '0) || (i_flush && !i_empty)) begin
          state_d     = REQ;
          remaining_d = (i_burst_len > MAX_LEN) ? MAX_LEN : i_burst_len;
          flush_d     = i_flush;
        end
      end
      REQ: state_d = WAIT;
      WAIT: begin
        if (i_rd_dv) begin
          tx_data_d = i_rd_data;
          tx_dv_d   = 1'b1;
          if (!flush_q && remaining_q != '0) begin
            remaining_d = remaining_q - LEN_W'(1);
          end
          state_d = HOLD;
        end else begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      HOLD: begin
        // A flush request raised mid-burst takes over from the burst count here.
        if (xfer) begin
          tx_dv_d = 1'b0;
          flush_d = flush_eff;
          if (!i_empty && (flush_eff || remaining_q != '0)) begin
            state_d = REQ;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        flush_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      flush_q     <= 1'b0;
      tx_dv_q     <= 1'b0;
      tx_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      flush_q     <= flush_d;
      tx_dv_q     <= tx_dv_d;
      tx_data_q   <= tx_data_d;
      err_q       <= err_d;
    end
  end

  assign o_rd_en      = (state_q == REQ);
  assign o_busy       = (state_q != IDLE);
  assign o_burst_done = (state_q == DONE);
  assign o_tx_dv      = tx_dv_q;
  assign o_tx_data    = tx_data_q;
  assign o_err        = err_q;

`ifdef FIFO_BURST_READER_STATS_EN
  logic [STATS_W-1:0] words_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      words_q <= '0;
    end else if (xfer && words_q != '1) begin
      words_q <= words_q + STATS_W'(1);
    end
  end

  assign o_words_sent = words_q;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: stub 4-deep FIFO, directed scenarios and random bursts.
module tb_fifo_burst_reader;

  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 16;
  localparam int STATS_W   = 16;
  localparam int LEN_W     = $clog2(MAX_BURST + 1);
  localparam int DEPTH     = 4;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic [LEN_W-1:0] i_burst_len;
  logic             i_flush;
  logic             o_rd_en;
  logic             i_rd_dv = 1'b0;
  logic [WIDTH-1:0] i_rd_data = '0;
  logic             i_empty;
  logic             i_ae_flag;
  logic             o_tx_dv;
  logic [WIDTH-1:0] o_tx_data;
  logic             i_tx_ready;
  logic             o_busy;
  logic             o_burst_done;
  logic             o_err;
`ifdef FIFO_BURST_READER_STATS_EN
  logic [STATS_W-1:0] o_words_sent;
`endif

  fifo_burst_reader #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST), .STATS_W(STATS_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_burst_len(i_burst_len), .i_flush(i_flush),
    .o_rd_en(o_rd_en), .i_rd_dv(i_rd_dv), .i_rd_data(i_rd_data), .i_empty(i_empty),
    .i_ae_flag(i_ae_flag), .o_tx_dv(o_tx_dv), .o_tx_data(o_tx_data), .i_tx_ready(i_tx_ready),
    .o_busy(o_busy), .o_burst_done(o_burst_done),
`ifdef FIFO_BURST_READER_STATS_EN
    .o_words_sent(o_words_sent),
`endif
    .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Stub FIFO: one-cycle read latency, almost-empty at one word or fewer.
  logic [WIDTH-1:0] fifoMem [DEPTH];
  int               wrPtr = 0, rdPtr = 0, fifoCount = 0;
  logic             pushEn = 1'b0;
  logic [WIDTH-1:0] pushData = '0;
  bit               stubNoDv = 1'b0;
  bit               forceAeLow = 1'b0;

  assign i_empty   = (fifoCount == 0);
  assign i_ae_flag = forceAeLow ? 1'b0 : (fifoCount <= 1);

  always @(posedge i_clk) begin : stubFifo
    int nextCount;
    nextCount = fifoCount;
    i_rd_dv <= 1'b0;
    if (o_rd_en && fifoCount > 0) begin
      i_rd_data <= fifoMem[rdPtr];
      i_rd_dv   <= !stubNoDv;
      rdPtr     <= (rdPtr + 1) % DEPTH;
      nextCount--;
    end
    if (pushEn && fifoCount < DEPTH) begin
      fifoMem[wrPtr] <= pushData;
      wrPtr          <= (wrPtr + 1) % DEPTH;
      nextCount++;
    end
    fifoCount <= nextCount;
  end

  // Downstream monitor, sampled mid-cycle.
  logic [WIDTH-1:0] gotWords [256];
  int               gotCount = 0, rdCount = 0, doneCount = 0;
  int               overlapErr = 0, rdEmptyErr = 0, stableErr = 0;
  bit               holdPrev = 1'b0;
  logic [WIDTH-1:0] holdData = '0;

  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_tx_dv && i_tx_ready) begin
        gotWords[gotCount % 256] = o_tx_data;
        gotCount++;
      end
      if (o_rd_en) rdCount++;
      if (o_burst_done) doneCount++;
      if (o_rd_en && o_tx_dv) overlapErr++;
      if (o_rd_en && i_empty) rdEmptyErr++;
      if (holdPrev && (!o_tx_dv || o_tx_data != holdData)) stableErr++;
    end
    holdPrev = !i_rst && o_tx_dv && !i_tx_ready;
    holdData = o_tx_data;
  end

  logic [WIDTH-1:0] modelQ[$];

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic pushWord(input logic [WIDTH-1:0] d);
    pushEn   = 1'b1;
    pushData = d;
    tick();
    pushEn = 1'b0;
    modelQ.push_back(d);
  endtask

  // Expected words: the next n FIFO entries, n = all of them when flushing, else min(saturated len, count).
  task automatic applyStimulus(input int len, input bit flush, input bit randReady,
                               input bit convFlush, input bit expectStart);
    int startGot, startRd, startDone, sz, sat, n, got;
    bit started, finished;
    logic [WIDTH-1:0] expWord;
    startGot  = gotCount;
    startRd   = rdCount;
    startDone = doneCount;
    started   = 1'b0;
    finished  = 1'b0;
    sz  = modelQ.size();
    sat = (len > MAX_BURST) ? MAX_BURST : len;
    if (!expectStart) n = 0;
    else if (flush || convFlush) n = sz;
    else n = (sat < sz) ? sat : sz;
    i_burst_len = LEN_W'(len);
    i_flush     = flush;
    i_tx_ready  = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      tick();
      if (!started && o_busy) begin
        started     = 1'b1;
        i_burst_len = '0;
        i_flush     = convFlush;
      end
      if (started && doneCount > startDone && !o_busy) begin
        finished = 1'b1;
        break;
      end
      if (!started && cyc >= 8) break;
      i_tx_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    i_burst_len = '0;
    i_flush     = 1'b0;
    i_tx_ready  = 1'b1;
    got = gotCount - startGot;
    checkOutput("burstStarted", 32'(started), 32'(expectStart));
    if (expectStart) checkOutput("burstFinished", 32'(finished), 1);
    checkOutput("wordCount", got, n);
    checkOutput("readPulses", rdCount - startRd, n);
    checkOutput("donePulses", doneCount - startDone, expectStart ? 1 : 0);
    for (int i = 0; i < n; i++) begin
      expWord = modelQ.pop_front();
      if (i < got) checkOutput($sformatf("txWord%0d", i), gotWords[(startGot + i) % 256], expWord);
    end
  endtask

  initial begin
    bit seen;
    int k, len, sz;
    bit fl;
    i_rst = 1'b1; i_burst_len = '0; i_flush = 1'b0; i_tx_ready = 1'b1;
    tick(); tick();
    checkOutput("rstRdEn", o_rd_en, 0);
    checkOutput("rstTxDv", o_tx_dv, 0);
    checkOutput("rstTxData", o_tx_data, 0);
    checkOutput("rstBusy", o_busy, 0);
    checkOutput("rstDone", o_burst_done, 0);
    checkOutput("rstErr", o_err, 0);
    i_rst = 1'b0;
    tick();

    $display("[TB] burst of 3");
    for (int i = 0; i < 4; i++) pushWord(8'h30 + 8'(i));
    applyStimulus(3, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("leftCount", fifoCount, 1);
    checkOutput("leftWord", fifoMem[rdPtr], 8'h33);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("[TB] flush single word");
    pushWord(8'hAB);
    applyStimulus(4, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("flushEmpty", i_empty, 1);
    checkOutput("flushIdle", o_busy, 0);

    $display("[TB] backpressure");
    for (int i = 0; i < 4; i++) pushWord(8'h30 + 8'(i));
    k = gotCount;
    i_tx_ready = 1'b0;
    i_burst_len = LEN_W'(3);
    tick();
    i_burst_len = '0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (o_tx_dv) seen = 1'b1;
      else tick();
    end
    checkOutput("bpValidSeen", 32'(seen), 1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bpValid", o_tx_dv, 1);
      checkOutput("bpData", o_tx_data, 8'h30);
      checkOutput("bpNoRead", o_rd_en, 0);
      tick();
    end
    i_tx_ready = 1'b1;
    for (int i = 0; i < 40 && o_busy; i++) tick();
    checkOutput("bpIdle", o_busy, 0);
    checkOutput("bpWords", gotCount - k, 3);
    for (int i = 0; i < 3; i++) checkOutput("bpWord", gotWords[(k + i) % 256], modelQ.pop_front());
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("[TB] early empty");
    forceAeLow = 1'b1;
    pushWord(8'h51); pushWord(8'h52);
    applyStimulus(4, 1'b0, 1'b0, 1'b0, 1'b1);
    forceAeLow = 1'b0;

    $display("[TB] flush raised mid-burst");
    for (int i = 0; i < 4; i++) pushWord(8'h60 + 8'(i));
    applyStimulus(1, 1'b0, 1'b1, 1'b1, 1'b1);

    $display("[TB] random bursts");
    for (int it = 0; it < 12; it++) begin
      k = $urandom_range(0, DEPTH - modelQ.size());
      for (int i = 0; i < k; i++) pushWord(8'($urandom));
      len = $urandom_range(0, 31);
      fl  = ($urandom_range(0, 3) == 0);
      sz  = modelQ.size();
      applyStimulus(len, fl, 1'b1, 1'b0, (sz > 1 && len != 0) || (fl && sz > 0));
    end
    applyStimulus(0, 1'b1, 1'b0, 1'b0, modelQ.size() > 0);

    $display("[TB] read latency fault");
    stubNoDv = 1'b1;
    pushWord(8'h71); pushWord(8'h72);
    i_burst_len = LEN_W'(1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (o_rd_en) seen = 1'b1;
    end
    i_burst_len = '0;
    checkOutput("faultReadSeen", 32'(seen), 1);
    tick();
    checkOutput("faultErrEarly", o_err, 0);
    tick();
    checkOutput("faultErr", o_err, 1);
    checkOutput("faultNoTx", o_tx_dv, 0);
    checkOutput("faultDone", o_burst_done, 1);
    tick();
    checkOutput("faultIdle", o_busy, 0);
    void'(modelQ.pop_front());
    repeat (4) tick();
    checkOutput("errSticky", o_err, 1);
    stubNoDv = 1'b0;

`ifdef FIFO_BURST_READER_STATS_EN
    checkOutput("wordsSent", o_words_sent, gotCount);
`endif

    $display("[TB] reset during hold");
    forceAeLow = 1'b1;
    i_tx_ready = 1'b0;
    i_burst_len = LEN_W'(4);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (o_tx_dv) seen = 1'b1;
    end
    i_burst_len = '0;
    checkOutput("holdSeen", 32'(seen), 1);
    checkOutput("holdData", o_tx_data, modelQ.pop_front());
    i_rst = 1'b1;
    tick();
    checkOutput("midRstTxDv", o_tx_dv, 0);
    checkOutput("midRstBusy", o_busy, 0);
    checkOutput("midRstErr", o_err, 0);
`ifdef FIFO_BURST_READER_STATS_EN
    checkOutput("midRstWords", o_words_sent, 0);
`endif
    i_rst = 1'b0;
    forceAeLow = 1'b0;
    i_tx_ready = 1'b1;
    repeat (3) tick();
    checkOutput("finalEmpty", i_empty, 1);
    checkOutput("finalIdle", o_busy, 0);
    checkOutput("readDuringValid", overlapErr, 0);
    checkOutput("readWhileEmpty", rdEmptyErr, 0);
    checkOutput("holdStable", stableErr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
